pkt_gen: RTL and testbench
==========================

Name: pkt_gen

Overview:
- Self-test packet generator for the capture path.
- Drives the 24 pkt_gen_data_* lanes that feed the self-test/ADC data selector downstream.
- Produces framed, deterministic test patterns: fixed, ramp, toggle and per-lane PRBS7. Each pattern is checkable downstream without the analog front end.
- Runs only while rf_self_test_mode is high; otherwise idles with zeroed outputs.

Parameters:
- NUM_LANES, 24, number of output lanes
- LANE_W, 36, bits per lane
- SAMP_W, 12, bits per sample; SPL = LANE_W/SAMP_W = 3 samples per lane
- LEN_W, 16, width of frame length field

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- rf_self_test_mode  input  1  generator enable; also the downstream select
- rf_pkt_gen_mode  input  2  0=fixed, 1=ramp, 2=toggle, 3=PRBS7
- rf_pkt_gen_fixed  input  12  fixed-mode sample value
- rf_pkt_gen_len  input  LEN_W  data cycles per frame; 0 = continuous
- rf_pkt_gen_gap  input  8  idle cycles between frames
- rf_pkt_gen_err_inject  input  1  error-inject pulse (only with PKT_GEN_ERR_INJECT_EN)
- pkt_gen_data_0 .. pkt_gen_data_23  output  36 each  lane data
- pkt_gen_valid  output  1  lane data valid this cycle
- pkt_gen_frame_start  output  1  first data cycle of a frame

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- All outputs are registered.
- Reset values: all data 0, valid 0, frame_start 0, FSM IDLE, ramp base 0, LFSRs at seed.
- Sample packing: sample k of a lane occupies bits [12k+11:12k]. Global sample index s = lane*3 + k.
- FSM states IDLE, RUN, GAP.
- IDLE → RUN when rf_self_test_mode is sampled high.
  - The next cycle outputs the first word with valid=1 and frame_start=1.
  - Latency is 1 cycle from the enable edge.
- Frame start:
  - Shadow-latch mode, fixed, len and gap.
  - Clear the word counter and ramp base to 0.
  - Reseed every LFSR.
- Config changes mid-frame are ignored until the next frame start.
- RUN:
  - Emit one word per cycle with valid=1.
  - After len words (len≠0): go to GAP if gap≠0. If gap=0, start a new frame on the next cycle (back-to-back frame_start).
  - len=0: never leaves RUN; no further frame_start.
- GAP: valid=0 and data=0 for exactly gap cycles, then a new frame.
- Any state, rf_self_test_mode sampled low → IDLE. The next cycle has valid=0, frame_start=0, data=0.
  - Re-enable always starts a fresh frame.
- Pattern modes:
  - Fixed: every sample = fixed.
  - Ramp: sample = (base + s) mod 2^12. base += 72 per data cycle, mod 2^12 (wraps).
  - Toggle: all samples 0xAAA on even words of the frame, 0x555 on odd words.
  - PRBS7 (x^7+x^6+1), one LFSR per lane:
    - Seed = lane+1.
    - Each data cycle advances 36 steps.
    - Output bits are placed MSB-first into bit 35..0.
- Ramp base and LFSRs advance only on data cycles (not in GAP or IDLE).

Optional Feature:
- Macro: PKT_GEN_ERR_INJECT_EN.
- Defined:
  - An rf_pkt_gen_err_inject pulse during a RUN cycle inverts bit 0 of pkt_gen_data_0 on that cycle's output word, for one word only.
  - Generator state (base, LFSR) is unaffected.
  - A pulse in IDLE/GAP is dropped.
- Undefined: the port exists but is ignored; no inversion logic is built.

Decomposition:
- Package pkt_gen_pkg holds:
  - Mode encodings: PKT_GEN_FIXED, PKT_GEN_RAMP, PKT_GEN_TOGGLE, PKT_GEN_PRBS.
  - FSM state encodings.
  - Constants: SPL, TOGGLE_A = 12'hAAA, TOGGLE_B = 12'h555, PRBS seed rule.
- Sub-module pkt_gen_prbs_lane: one 7-bit LFSR with 36-step unrolled advance, reseed input and 36-bit output. Instantiated NUM_LANES times via generate.

Test Plan:
- Fixed 0xABC, len=4, gap=2, enable:
  - 1 cycle later frame_start=1.
  - 4 valid words, all lanes 0xABCABCABC.
  - 2 cycles valid=0, data 0.
  - Then frame_start again.
- Ramp, len=0:
  - Word0: lane0 = 0x002001000, lane23 = {71,70,69}.
  - Word1: lane0 = {74,73,72}.
  - Word57: lane0 sample0 = 8 (wrap).
- Toggle, len=3, gap=0:
  - Words 0xAAA-filled, then 0x555, then 0xAAA.
  - frame_start on the immediately following cycle; pattern restarts at 0xAAA.
- PRBS, len=2: lane n output equals a reference PRBS7 seeded n+1. The second frame repeats the first exactly.
- Disable at word 2 of a len=10 frame:
  - Next cycle valid=0, data=0.
  - Re-enable: frame_start with ramp restarting at 0.
- Change mode ramp→fixed mid-frame: current frame stays ramp; the next frame is fixed.
- With PKT_GEN_ERR_INJECT_EN, a pulse at word 1: only lane0 bit0 of word 1 is inverted; word 2 is correct.

Source files
------------

// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared constants, mode/state encodings and PRBS seed rule for
// the self-test packet generator.
// No ports; imported by pkt_gen and pkt_gen_prbs_lane.
package pkt_gen_pkg;

  localparam int NUM_LANES = 24;
  localparam int LANE_W    = 36;
  localparam int SAMP_W    = 12;
  localparam int LEN_W     = 16;
  localparam int GAP_W     = 8;
  localparam int SPL       = LANE_W / SAMP_W;

  // Ramp base moves by the number of samples in one word so consecutive
  // words continue the same count.
  localparam logic [SAMP_W-1:0] RAMP_STEP = SAMP_W'(NUM_LANES * SPL);

  localparam logic [SAMP_W-1:0] TOGGLE_A = 12'hAAA;
  localparam logic [SAMP_W-1:0] TOGGLE_B = 12'h555;

  typedef enum logic [1:0] {
    PKT_GEN_FIXED  = 2'd0,
    PKT_GEN_RAMP   = 2'd1,
    PKT_GEN_TOGGLE = 2'd2,
    PKT_GEN_PRBS   = 2'd3
  } pkt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } pkt_state_e;

  // Lane n starts from n+1 so no lane ever holds the all-zero lock state.
  function automatic logic [6:0] prbs_seed(input int lane);
    return 7'(lane + 1);
  endfunction

endpackage

// File: rtl/pkt_gen_prbs_lane.sv
// pkt_gen_prbs_lane: one PRBS7 (x^7+x^6+1) generator advancing 36 steps per word.
// Ports: clk, rst (sync, active-high), reseed_i (use SEED as the current state),
//        adv_i (commit the 36-step advance), dat_o (36 bits, first bit at [35]).
module pkt_gen_prbs_lane
  import pkt_gen_pkg::*;
#(
  parameter logic [6:0] SEED = 7'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reseed_i,
  input  logic              adv_i,
  output logic [LANE_W-1:0] dat_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Reseed takes effect on the same word, so the frame-start word is drawn
  // from SEED rather than from the stale register.
  always_comb begin : advance
    logic [6:0] s;
    logic       nb;
    s     = reseed_i ? SEED : lfsr_q;
    nb    = 1'b0;
    dat_o = '0;
    for (int i = 0; i < LANE_W; i++) begin
      nb              = s[6] ^ s[5];
      dat_o[LANE_W-1-i] = nb;
      s               = {s[5:0], nb};
    end
    lfsr_d = adv_i ? s : (reseed_i ? SEED : lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/pkt_gen.sv
// pkt_gen: framed self-test pattern generator (fixed/ramp/toggle/PRBS7) on 24x36-bit lanes.
// Ports: clk, rst (sync, active-high), rf_* config, pkt_gen_data_0..23, pkt_gen_valid,
//        pkt_gen_frame_start; all outputs registered. Macro PKT_GEN_ERR_INJECT_EN enables bit-0 error inject.
module pkt_gen
  import pkt_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_self_test_mode,
  input  logic [1:0]        rf_pkt_gen_mode,
  input  logic [11:0]       rf_pkt_gen_fixed,
  input  logic [LEN_W-1:0]  rf_pkt_gen_len,
  input  logic [7:0]        rf_pkt_gen_gap,
  input  logic              rf_pkt_gen_err_inject,
  output logic [35:0]       pkt_gen_data_0,  pkt_gen_data_1,  pkt_gen_data_2,  pkt_gen_data_3,
  output logic [35:0]       pkt_gen_data_4,  pkt_gen_data_5,  pkt_gen_data_6,  pkt_gen_data_7,
  output logic [35:0]       pkt_gen_data_8,  pkt_gen_data_9,  pkt_gen_data_10, pkt_gen_data_11,
  output logic [35:0]       pkt_gen_data_12, pkt_gen_data_13, pkt_gen_data_14, pkt_gen_data_15,
  output logic [35:0]       pkt_gen_data_16, pkt_gen_data_17, pkt_gen_data_18, pkt_gen_data_19,
  output logic [35:0]       pkt_gen_data_20, pkt_gen_data_21, pkt_gen_data_22, pkt_gen_data_23,
  output logic              pkt_gen_valid,
  output logic              pkt_gen_frame_start
);

  pkt_state_e        state_q, state_d;
  pkt_mode_e         mode_q, mode_d, mode_eff;
  logic [SAMP_W-1:0] fixed_q, fixed_d, fixed_eff;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_eff;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [SAMP_W-1:0] base_q, base_d, base_eff;
  logic              fs, emit;

  logic [LANE_W-1:0] data_q [NUM_LANES];
  logic [LANE_W-1:0] data_d [NUM_LANES];
  logic [LANE_W-1:0] prbs_dat [NUM_LANES];
  logic              valid_q, fs_q;

  // Frame sequencing. fs marks a frame-start word; emit marks any data word.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    fixed_d   = fixed_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    fs        = 1'b0;
    emit      = 1'b0;
    if (!rf_self_test_mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: fs = 1'b1;
        ST_RUN: begin
          // cnt_q counts words already emitted in this frame.
          if (len_q != '0 && cnt_q == len_q) begin
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = 8'd1;
            end else begin
              fs = 1'b1;
            end
          end else begin
            emit = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == gap_q) fs = 1'b1;
          else                    gap_cnt_d = gap_cnt_q + 8'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (fs) begin
      emit    = 1'b1;
      state_d = ST_RUN;
      mode_d  = pkt_mode_e'(rf_pkt_gen_mode);
      fixed_d = rf_pkt_gen_fixed;
      len_d   = rf_pkt_gen_len;
      gap_d   = rf_pkt_gen_gap;
    end
  end

  // The frame-start word uses the live config and a zeroed generator state.
  assign mode_eff  = fs ? pkt_mode_e'(rf_pkt_gen_mode) : mode_q;
  assign fixed_eff = fs ? rf_pkt_gen_fixed : fixed_q;
  assign base_eff  = fs ? '0 : base_q;
  assign cnt_eff   = fs ? '0 : cnt_q;
  assign base_d    = emit ? base_eff + RAMP_STEP : base_q;
  assign cnt_d     = emit ? cnt_eff + 1'b1 : cnt_q;

  always_comb begin : word_gen
    logic [SAMP_W-1:0] samp;
    samp = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      data_d[l] = '0;
      if (emit) begin
        if (mode_eff == PKT_GEN_PRBS) begin
          data_d[l] = prbs_dat[l];
        end else begin
          for (int k = 0; k < SPL; k++) begin
            case (mode_eff)
              PKT_GEN_FIXED:  samp = fixed_eff;
              PKT_GEN_RAMP:   samp = base_eff + SAMP_W'(l * SPL + k);
              PKT_GEN_TOGGLE: samp = cnt_eff[0] ? TOGGLE_B : TOGGLE_A;
              default:        samp = '0;
            endcase
            data_d[l][k*SAMP_W +: SAMP_W] = samp;
          end
        end
      end
    end
`ifdef PKT_GEN_ERR_INJECT_EN
    // Output-only corruption: generator state is untouched.
    if (rf_pkt_gen_err_inject && emit && state_q == ST_RUN)
      data_d[0][0] = ~data_d[0][0];
`endif
  end

`ifndef PKT_GEN_ERR_INJECT_EN
  logic unused_err_inject;
  assign unused_err_inject = rf_pkt_gen_err_inject;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pkt_gen_prbs_lane #(.SEED(prbs_seed(g))) u_prbs (
      .clk      (clk),
      .rst      (rst),
      .reseed_i (fs),
      .adv_i    (emit),
      .dat_o    (prbs_dat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= PKT_GEN_FIXED;
      fixed_q   <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      base_q    <= '0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      fixed_q   <= fixed_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      base_q    <= base_d;
      valid_q   <= emit;
      fs_q      <= fs;
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= data_d[l];
    end
  end

  assign pkt_gen_valid       = valid_q;
  assign pkt_gen_frame_start = fs_q;
  assign pkt_gen_data_0  = data_q[0];
  assign pkt_gen_data_1  = data_q[1];
  assign pkt_gen_data_2  = data_q[2];
  assign pkt_gen_data_3  = data_q[3];
  assign pkt_gen_data_4  = data_q[4];
  assign pkt_gen_data_5  = data_q[5];
  assign pkt_gen_data_6  = data_q[6];
  assign pkt_gen_data_7  = data_q[7];
  assign pkt_gen_data_8  = data_q[8];
  assign pkt_gen_data_9  = data_q[9];
  assign pkt_gen_data_10 = data_q[10];
  assign pkt_gen_data_11 = data_q[11];
  assign pkt_gen_data_12 = data_q[12];
  assign pkt_gen_data_13 = data_q[13];
  assign pkt_gen_data_14 = data_q[14];
  assign pkt_gen_data_15 = data_q[15];
  assign pkt_gen_data_16 = data_q[16];
  assign pkt_gen_data_17 = data_q[17];
  assign pkt_gen_data_18 = data_q[18];
  assign pkt_gen_data_19 = data_q[19];
  assign pkt_gen_data_20 = data_q[20];
  assign pkt_gen_data_21 = data_q[21];
  assign pkt_gen_data_22 = data_q[22];
  assign pkt_gen_data_23 = data_q[23];

endmodule

// File: tb/tb_pkt_gen.sv
module tb_pkt_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] fixed;
  logic [15:0] len;
  logic [7:0]  gap;
  logic        inj;
  logic [35:0] lane [24];
  logic        valid, fstart;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pkt_gen dut (
    .clk(clk), .rst(rst), .rf_self_test_mode(en), .rf_pkt_gen_mode(mode),
    .rf_pkt_gen_fixed(fixed), .rf_pkt_gen_len(len), .rf_pkt_gen_gap(gap),
    .rf_pkt_gen_err_inject(inj),
    .pkt_gen_data_0(lane[0]),   .pkt_gen_data_1(lane[1]),   .pkt_gen_data_2(lane[2]),
    .pkt_gen_data_3(lane[3]),   .pkt_gen_data_4(lane[4]),   .pkt_gen_data_5(lane[5]),
    .pkt_gen_data_6(lane[6]),   .pkt_gen_data_7(lane[7]),   .pkt_gen_data_8(lane[8]),
    .pkt_gen_data_9(lane[9]),   .pkt_gen_data_10(lane[10]), .pkt_gen_data_11(lane[11]),
    .pkt_gen_data_12(lane[12]), .pkt_gen_data_13(lane[13]), .pkt_gen_data_14(lane[14]),
    .pkt_gen_data_15(lane[15]), .pkt_gen_data_16(lane[16]), .pkt_gen_data_17(lane[17]),
    .pkt_gen_data_18(lane[18]), .pkt_gen_data_19(lane[19]), .pkt_gen_data_20(lane[20]),
    .pkt_gen_data_21(lane[21]), .pkt_gen_data_22(lane[22]), .pkt_gen_data_23(lane[23]),
    .pkt_gen_valid(valid), .pkt_gen_frame_start(fstart)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    tick();
    tick();
  endtask

  // Reference PRBS7 as a bit recurrence x[n] = x[n-7] ^ x[n-6]; the seed
  // provides x[0..6] oldest first, and word w is x[7+36w .. 42+36w] MSB-first.
  function automatic logic [35:0] prbs_ref(input int seed, input int w);
    logic x [0:200];
    logic [6:0] sd;
    logic [35:0] r;
    sd = 7'(seed);
    for (int i = 0; i < 7; i++) x[i] = sd[6-i];
    for (int n = 7; n <= 200; n++) x[n] = x[n-7] ^ x[n-6];
    r = '0;
    for (int j = 0; j < 36; j++) r[35-j] = x[7 + 36*w + j];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; fixed = '0; len = '0; gap = '0; inj = 1'b0;
    tick(); tick();
    n_cmp++;
    if (valid !== 1'b0 || fstart !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: valid=%b fs=%b, want 0 0", valid, fstart);
    end
    n_cmp++;
    if (lane[0] !== 36'h0 || lane[23] !== 36'h0) begin
      n_bad++; $display("FAIL reset_data: l0=%h l23=%h, want 0", lane[0], lane[23]);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_valid: got %b want 0", valid);
    end
  endtask

  task automatic test_fixed();
    logic ok;
    mode = 2'd0; fixed = 12'hABC; len = 16'd4; gap = 8'd2;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ok = 1'b1;
      for (int l = 0; l < 24; l++) if (lane[l] !== 36'hABCABCABC) ok = 1'b0;
      n_cmp++;
      if (!ok || valid !== 1'b1 || fstart !== (i == 0)) begin
        n_bad++;
        $display("FAIL fixed_word%0d: l0=%h v=%b fs=%b, want abcabcabc 1 %0d", i, lane[0], valid, fstart, i == 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0 || fstart !== 1'b0 || lane[0] !== 36'h0 || lane[23] !== 36'h0) begin
        n_bad++; $display("FAIL fixed_gap%0d: v=%b fs=%b l0=%h, want 0 0 0", i, valid, fstart, lane[0]);
      end
    end
    tick();
    n_cmp++;
    if (fstart !== 1'b1 || valid !== 1'b1 || lane[5] !== 36'hABCABCABC) begin
      n_bad++; $display("FAIL fixed_restart: fs=%b v=%b l5=%h, want 1 1 abcabcabc", fstart, valid, lane[5]);
    end
    go_idle();
  endtask

  task automatic test_ramp();
    mode = 2'd1; len = 16'd0; gap = 8'd0;
    en = 1'b1;
    tick();
    n_cmp++;
    if (lane[0] !== 36'h002001000 || fstart !== 1'b1) begin
      n_bad++; $display("FAIL ramp_w0_l0: l0=%h fs=%b, want 002001000 1", lane[0], fstart);
    end
    n_cmp++;
    if (lane[23] !== {12'd71, 12'd70, 12'd69}) begin
      n_bad++; $display("FAIL ramp_w0_l23: got %h want %h", lane[23], {12'd71, 12'd70, 12'd69});
    end
    tick();
    n_cmp++;
    if (lane[0] !== {12'd74, 12'd73, 12'd72} || fstart !== 1'b0) begin
      n_bad++; $display("FAIL ramp_w1: l0=%h fs=%b, want %h 0", lane[0], fstart, {12'd74, 12'd73, 12'd72});
    end
    for (int i = 0; i < 56; i++) tick();
    n_cmp++;
    if (lane[0] !== {12'd10, 12'd9, 12'd8} || valid !== 1'b1 || fstart !== 1'b0) begin
      n_bad++; $display("FAIL ramp_wrap_w57: l0=%h v=%b fs=%b, want 00a009008 1 0", lane[0], valid, fstart);
    end
    go_idle();
  endtask

  task automatic test_toggle();
    logic [35:0] exp;
    logic ok;
    mode = 2'd2; len = 16'd3; gap = 8'd0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (i == 1) ? 36'h555555555 : 36'hAAAAAAAAA;
      ok = 1'b1;
      for (int l = 0; l < 24; l++) if (lane[l] !== exp) ok = 1'b0;
      n_cmp++;
      if (!ok || valid !== 1'b1 || fstart !== (i == 0 || i == 3)) begin
        n_bad++;
        $display("FAIL toggle_word%0d: l0=%h v=%b fs=%b, want %h 1 %0d", i, lane[0], valid, fstart, exp, i == 0 || i == 3);
      end
    end
    go_idle();
  endtask

  task automatic test_prbs();
    logic [35:0] exp;
    mode = 2'd3; len = 16'd2; gap = 8'd0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (fstart !== (i == 0 || i == 2)) begin
        n_bad++; $display("FAIL prbs_fs%0d: got %b want %0d", i, fstart, i == 0 || i == 2);
      end
      for (int l = 0; l < 24; l++) begin
        exp = prbs_ref(l + 1, i % 2);
        n_cmp++;
        if (lane[l] !== exp) begin
          n_bad++; $display("FAIL prbs_w%0d_l%0d: got %h want %h", i, l, lane[l], exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_disable();
    mode = 2'd1; len = 16'd10; gap = 8'd0;
    en = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (lane[0] !== {12'd146, 12'd145, 12'd144}) begin
      n_bad++; $display("FAIL dis_w2: got %h want %h", lane[0], {12'd146, 12'd145, 12'd144});
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 1'b0 || fstart !== 1'b0 || lane[0] !== 36'h0 || lane[23] !== 36'h0) begin
      n_bad++; $display("FAIL dis_off: v=%b fs=%b l0=%h, want 0 0 0", valid, fstart, lane[0]);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (fstart !== 1'b1 || valid !== 1'b1 || lane[0] !== 36'h002001000) begin
      n_bad++; $display("FAIL dis_reen: fs=%b v=%b l0=%h, want 1 1 002001000", fstart, valid, lane[0]);
    end
    go_idle();
  endtask

  task automatic test_mode_change();
    mode = 2'd1; len = 16'd2; gap = 8'd1;
    en = 1'b1;
    tick();
    mode = 2'd0; fixed = 12'h123;
    tick();
    n_cmp++;
    if (lane[0] !== {12'd74, 12'd73, 12'd72}) begin
      n_bad++; $display("FAIL chg_midframe: got %h want %h", lane[0], {12'd74, 12'd73, 12'd72});
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0 || lane[0] !== 36'h0) begin
      n_bad++; $display("FAIL chg_gap: v=%b l0=%h, want 0 0", valid, lane[0]);
    end
    tick();
    n_cmp++;
    if (fstart !== 1'b1 || lane[0] !== 36'h123123123 || lane[23] !== 36'h123123123) begin
      n_bad++; $display("FAIL chg_next: fs=%b l0=%h, want 1 123123123", fstart, lane[0]);
    end
    go_idle();
  endtask

  task automatic test_err_inject();
    logic [35:0] exp1;
`ifdef PKT_GEN_ERR_INJECT_EN
    exp1 = 36'h0F00F00F1;
`else
    exp1 = 36'h0F00F00F0;
`endif
    mode = 2'd0; fixed = 12'h0F0; len = 16'd4; gap = 8'd0;
    en = 1'b1;
    tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    n_cmp++;
    if (lane[0] !== exp1 || lane[1] !== 36'h0F00F00F0) begin
      n_bad++; $display("FAIL inj_w1: l0=%h l1=%h, want %h 0f00f00f0", lane[0], lane[1], exp1);
    end
    tick();
    n_cmp++;
    if (lane[0] !== 36'h0F00F00F0) begin
      n_bad++; $display("FAIL inj_w2: got %h want 0f00f00f0", lane[0]);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_ramp();
    test_toggle();
    test_prbs();
    test_disable();
    test_mode_change();
    test_err_inject();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time limit reached");
    $fatal(1);
  end

endmodule
